// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: command/ALU opcodes, sequencer states and opcode mapping
package alu_cmd_pkg;
    localparam logic [2:0] CMD_AND   = 3'b000;
    localparam logic [2:0] CMD_OR    = 3'b001;
    localparam logic [2:0] CMD_ADD   = 3'b010;
    localparam logic [2:0] CMD_SUB   = 3'b011;
    localparam logic [2:0] CMD_MUL   = 3'b100;
    localparam logic [2:0] CMD_CMPEQ = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
    function automatic logic [2:0] alu_op_of(input logic [2:0] cmd);
        return cmd == CMD_AND ? ALU_AND : cmd == CMD_OR ? ALU_OR : cmd == CMD_ADD ? ALU_ADD : ALU_SUB;
    endfunction
endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives an external 32-bit ALU from valid/ready commands, with shift-add multiply
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);
    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d, data_q, data_d, product;
    logic        zero_q, zero_d, err_q, err_d;
    assign cmd_ready = state_q == IDLE && !reset;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_data  = data_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;
    // during MUL, a_q is the shifting multiplicand and b_q the shifting multiplier
    assign product   = b_q[0] ? alu_r : acc_q;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        alu_x   = '0;
        alu_y   = '0;
        alu_op  = ALU_AND;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                op_d    = cmd_op;
                a_d     = cmd_a;
                b_d     = cmd_b;
                acc_d   = '0;
                data_d  = '0;
                zero_d  = 1'b0;
                err_d   = cmd_op > CMD_CMPEQ;
                state_d = cmd_op == CMD_MUL ? MUL : cmd_op > CMD_CMPEQ ? RESP : EXEC;
            end
            EXEC: begin
                alu_x   = a_q;
                alu_y   = b_q;
                alu_op  = alu_op_of(op_q);
                data_d  = op_q == CMD_CMPEQ ? {31'b0, alu_zero} : alu_r;
                zero_d  = (op_q == CMD_CMPEQ) ^ alu_zero;
                state_d = RESP;
            end
            MUL: begin
                alu_x  = acc_q;
                alu_y  = a_q;
                alu_op = ALU_ADD;
                acc_d  = product;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                if (b_q[31:1] == '0) begin
                    data_d  = product;
                    zero_d  = product == '0;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural ALU beside the sequencer
module tb_alu_cmd_sequencer;
    logic        clk = 0, reset = 1, cmd_valid = 0, cmd_ready, alu_zero, rsp_valid, rsp_ready = 1;
    logic        rsp_zero, rsp_err, busy;
    logic [2:0]  cmd_op = 0, alu_op;
    logic [31:0] cmd_a = 0, cmd_b = 0, alu_x, alu_y, alu_r, rsp_data;
    int          checks = 0, errors = 0;
    typedef struct {logic [31:0] d; logic z; logic e;} rsp_t;
    rsp_t sb[$];

    always #5 clk = ~clk;

    always_comb begin
        alu_r = alu_op == 3'b000 ? alu_x & alu_y : alu_op == 3'b001 ? alu_x | alu_y :
                alu_op == 3'b010 ? alu_x + alu_y : alu_op == 3'b110 ? alu_x - alu_y : 32'h0;
        alu_zero = alu_r == 32'h0;
    end

    alu_cmd_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_r(alu_r),
        .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.e = 0;
        case (op)
            3'd0: r.d = a & b;
            3'd1: r.d = a | b;
            3'd2: r.d = a + b;
            3'd3: r.d = a - b;
            3'd4: r.d = a * b;
            3'd5: r.d = {31'b0, a == b};
            default: begin r.d = 0; r.e = 1; end
        endcase
        r.z = op == 3'd5 ? a != b : op > 3'd5 ? 1'b0 : r.d == 0;
        return r;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [2:0] op);
        case (op)
            3'd0: return 3'b000;
            3'd1: return 3'b001;
            3'd2, 3'd4: return 3'b010;
            default: return 3'b110;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
        int k = 1;
        if (op > 3'd5) return 1;
        if (op != 3'd4) return 2;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return 1 + k;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int n = 0;
        logic [31:0] held;
        rsp_t e;
        wait_ready();
        sb.push_back(model(op, a, b));
        rsp_ready = hold == 0;
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1 cmd_valid = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("busy", busy, 1);
                if (op <= 3'd5) chk("alu_op", alu_op, exp_alu(op));
                else chk("alu_idle_op", {alu_op, alu_x}, 0);
            end
        end while (!rsp_valid && n < 60);
        chk("latency", n, latency(op, b));
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = i == 3;
            cmd_op = 3'd2;
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_ready", cmd_ready, 0);
            chk("hold_data", rsp_data, held);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_zero", rsp_zero, e.z);
        chk("rsp_err", rsp_err, e.e);
        @(negedge clk);
        chk("post_valid", rsp_valid, 0);
        chk("post_ready", cmd_ready, 1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_outs", {rsp_valid, busy, rsp_data, rsp_zero, rsp_err, alu_x, alu_y, alu_op}, 0);
        @(negedge clk);
        reset = 0;
        #1 chk("rst_release_ready", cmd_ready, 1);
        do_cmd(3'd2, 32'h7FFFFFFF, 32'h1, 0);
        do_cmd(3'd3, 32'h1234, 32'h1234, 0);
        do_cmd(3'd5, 32'd5, 32'd5, 0);
        do_cmd(3'd5, 32'd5, 32'd6, 0);
        do_cmd(3'd4, 32'd7, 32'd6, 0);
        do_cmd(3'd4, 32'd3, 32'd0, 0);
        do_cmd(3'd4, 32'h10000, 32'h10000, 0);
        do_cmd(3'd7, 32'hDEAD, 32'hBEEF, 0);
        do_cmd(3'd6, 32'h1, 32'h2, 0);
        do_cmd(3'd1, 32'hF0F0, 32'h0F0F, 0);
        do_cmd(3'd0, 32'hF0F0, 32'hFF00, 10);
        do_cmd(3'd4, 32'h12345, 32'hABCDE, 0);
        for (int i = 0; i < 6; i++)
            do_cmd(3'($urandom_range(0, 5)), $urandom, $urandom, 0);
        wait_ready();
        cmd_valid = 1; cmd_op = 3'd4; cmd_a = 32'hFFFFFFFF; cmd_b = 32'hFFFFFFFF;
        @(posedge clk);
        #1 cmd_valid = 0;
        repeat (10) @(negedge clk);
        chk("mid_mul_busy", busy, 1);
        reset = 1;
        #1 chk("reset_forces_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 0;
        #1 chk("after_reset_ready", cmd_ready, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) begin chk("dropped_rsp", {rsp_valid, busy}, 0); break; end
        end
        chk("after_reset_idle", {rsp_valid, busy}, 0);
        do_cmd(3'd2, 32'd1, 32'd1, 0);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected done");
        $fatal(1);
    end
endmodule
